// File: rtl/timer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_sequencer: runs REPS back-to-back periods of a fixed-period timer.  |
// | Optional TIMER_SEQ_WDOG_EN adds a WAIT/DRAIN watchdog and FAULT. Rev 1.0  |
// +--------------------------------------------------------------------------+
module timer_sequencer #(
  parameter int TIMER_N = 256,
  parameter int REPS_W  = 8,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 512
) (
  input  logic              CLK,
  input  logic              N_RESET,
  input  logic              GO,
  input  logic [REPS_W-1:0] REPS,
  input  logic              ABORT,
  output logic              START,
  input  logic              READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [REPS_W-1:0] RUNS
);

  if (TIMER_N < 2) begin : g_chk_timer_n
    $error("timer_sequencer: TIMER_N must be >= 2");
  end
  if (TIMEOUT <= TIMER_N) begin : g_chk_timeout
    $error("timer_sequencer: TIMEOUT must exceed TIMER_N");
  end

  localparam int              GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

`ifdef TIMER_SEQ_WDOG_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [REPS_W-1:0]  reps_q, reps_d;
  logic [REPS_W-1:0]  runs_q, runs_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [REPS_W-1:0]  runs_inc;
  logic               wd_hit;
  logic               start_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    reps_d    = reps_q;
    runs_d    = runs_q;
    gap_cnt_d = gap_cnt_q;
    runs_inc  = runs_q + 1'b1;
`ifdef TIMER_SEQ_WDOG_EN
    wd_hit    = (wd_cnt_q == WD_LAST);
`else
    wd_hit    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (GO) begin
          reps_d  = REPS;
          runs_d  = '0;
          state_d = (REPS == '0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        state_d = ABORT ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // ABORT beats a coincident READY; READY beats a coincident timeout
        if (ABORT) begin
          state_d = S_DRAIN;
        end else if (READY) begin
          runs_d = runs_inc;
          if (runs_inc == reps_q) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_ARM;
          end
        end else if (wd_hit) begin
`ifdef TIMER_SEQ_WDOG_EN
          state_d = S_FAULT;
`endif
        end
      end
      S_GAP: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_ARM;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (READY) begin
          state_d = S_IDLE;
        end else if (wd_hit) begin
`ifdef TIMER_SEQ_WDOG_EN
          state_d = S_FAULT;
`endif
        end
      end
`ifdef TIMER_SEQ_WDOG_EN
      S_FAULT: begin
        if (ABORT) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef TIMER_SEQ_WDOG_EN
  // Counts cycles spent in the current WAIT/DRAIN visit; any entry restarts it
  always_comb begin
    wd_cnt_d = '0;
    if ((state_d == S_WAIT || state_d == S_DRAIN) && state_d == state_q) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q   <= S_IDLE;
      reps_q    <= '0;
      runs_q    <= '0;
      gap_cnt_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TIMER_SEQ_WDOG_EN
      wd_cnt_q  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      reps_q    <= reps_d;
      runs_q    <= runs_d;
      gap_cnt_q <= gap_cnt_d;
      start_q   <= (state_d == S_ARM);
      busy_q    <= (state_d == S_ARM) || (state_d == S_WAIT) ||
                   (state_d == S_GAP) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
`ifdef TIMER_SEQ_WDOG_EN
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= (state_d == S_FAULT);
`endif
    end
  end

  assign START = start_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RUNS  = runs_q;
`ifdef TIMER_SEQ_WDOG_EN
  assign ERR   = err_q;
`else
  assign ERR   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_sequencer: randomized bench with a behavioural sequencer model.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_timer_sequencer;

  localparam int TIMER_N = 4;
  localparam int REPS_W  = 8;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              N_RESET = 1'b0;
  logic              GO = 1'b0;
  logic              ABORT = 1'b0;
  logic              READY = 1'b0;
  logic [REPS_W-1:0] REPS = '0;
  logic              START, BUSY, DONE, ERR;
  logic [REPS_W-1:0] RUNS;

  always #5 CLK = ~CLK;

  timer_sequencer #(
    .TIMER_N (TIMER_N),
    .REPS_W  (REPS_W),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .GO      (GO),
    .REPS    (REPS),
    .ABORT   (ABORT),
    .START   (START),
    .READY   (READY),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .RUNS    (RUNS)
  );

  // Behavioural model of what the sequencer is doing in the current cycle
  typedef enum {M_IDLE, M_ARM, M_WAIT, M_GAP, M_DONE, M_DRAIN, M_FAULT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int m_reps = 0, m_runs = 0, m_left = 0, m_wd = 0;

  int  cyc = 0;
  int  ready_at = -100;
  bit  stuck = 1'b0;
  bit  spur_en = 1'b0;
  bit  chk_en = 1'b1;
  int  n_checks = 0, n_fail = 0;
  int  err_first = -1;
  int  start_log[$];
  int  done_log[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_reps   = 0;
    m_runs   = 0;
    m_left   = 0;
    m_wd     = 0;
    ready_at = -100;
  endtask

  task automatic model_watchdog();
`ifdef TIMER_SEQ_WDOG_EN
    if (m_wd == TIMEOUT - 1) m_phase = M_FAULT;
    else m_wd++;
`endif
  endtask

  // One clock edge of the sequencer rules, using the inputs of the ending cycle
  task automatic model_step();
    case (m_phase)
      M_IDLE: if (GO) begin
        m_reps  = int'(REPS);
        m_runs  = 0;
        m_phase = (m_reps == 0) ? M_DONE : M_ARM;
      end
      M_ARM: begin
        m_phase = ABORT ? M_IDLE : M_WAIT;
        m_wd    = 0;
      end
      M_WAIT: begin
        if (ABORT) begin
          m_phase = M_DRAIN;
          m_wd    = 0;
        end else if (READY) begin
          m_runs = (m_runs + 1) % (1 << REPS_W);
          if (m_runs == m_reps) m_phase = M_DONE;
          else if (GAP > 0) begin
            m_phase = M_GAP;
            m_left  = GAP;
          end else m_phase = M_ARM;
        end else model_watchdog();
      end
      M_GAP: begin
        if (ABORT) m_phase = M_IDLE;
        else begin
          m_left--;
          if (m_left == 0) m_phase = M_ARM;
        end
      end
      M_DONE:  m_phase = M_IDLE;
      M_DRAIN: begin
        if (READY) m_phase = M_IDLE;
        else model_watchdog();
      end
      M_FAULT: if (ABORT) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  // Advance one cycle: timer model at negedge, edge, then drive READY
  task automatic cycle();
    @(negedge CLK);
    if (START && ready_at < cyc) ready_at = cyc + TIMER_N - 1;
    @(posedge CLK);
    if (N_RESET) model_step();
    cyc++;
    #1;
    GO    = 1'b0;
    ABORT = 1'b0;
    READY = (!stuck && cyc == ready_at) ||
            (spur_en && ready_at < cyc && m_phase != M_WAIT &&
             m_phase != M_DRAIN && ($urandom % 3 == 0));
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [REPS_W+3:0] got, exp;
      logic [REPS_W-1:0] exp_runs;
      exp_runs = REPS_W'(m_runs);
      got = {START, BUSY, DONE, ERR, RUNS};
      exp = {m_phase == M_ARM,
             m_phase == M_ARM || m_phase == M_WAIT || m_phase == M_GAP || m_phase == M_DRAIN,
             m_phase == M_DONE, m_phase == M_FAULT, exp_runs};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL outputs cycle %0d phase %s: got START/BUSY/DONE/ERR/RUNS=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                 cyc, m_phase.name(), START, BUSY, DONE, ERR, RUNS,
                 exp[REPS_W+3], exp[REPS_W+2], exp[REPS_W+1], exp[REPS_W], exp_runs);
      end
      if (START) start_log.push_back(cyc);
      if (DONE) done_log.push_back(cyc);
      if (ERR && err_first < 0) err_first = cyc;
    end
  end

  initial begin
    int t0;
    bit found;

    model_reset();
    repeat (2) cycle();
    check("reset START", int'(START), 0);
    check("reset BUSY", int'(BUSY), 0);
    check("reset RUNS", int'(RUNS), 0);
    N_RESET = 1'b1;
    repeat (2) cycle();

    // Two runs with a two-cycle gap: START at 1 and 7, DONE at 11
    start_log.delete(); done_log.delete();
    t0 = cyc; GO = 1'b1; REPS = 8'd2;
    repeat (14) cycle();
    check("gap start count", start_log.size(), 2);
    if (start_log.size() == 2) begin
      check("gap start0 cycle", start_log[0] - t0, 1);
      check("gap start1 cycle", start_log[1] - t0, 7);
    end
    check("gap done count", done_log.size(), 1);
    if (done_log.size() == 1) check("gap done cycle", done_log[0] - t0, 11);
    check("gap final RUNS", int'(RUNS), 2);

    // REPS of zero completes immediately without starting the timer
    start_log.delete(); done_log.delete();
    t0 = cyc; GO = 1'b1; REPS = 8'd0;
    repeat (4) cycle();
    check("zero start count", start_log.size(), 0);
    check("zero done count", done_log.size(), 1);
    if (done_log.size() == 1) check("zero done cycle", done_log[0] - t0, 1);
    check("zero RUNS", int'(RUNS), 0);

    // ABORT in WAIT drains the in-flight period, then a fresh GO works
    start_log.delete(); done_log.delete();
    t0 = cyc; GO = 1'b1; REPS = 8'd2;
    repeat (3) cycle();
    ABORT = 1'b1;
    repeat (2) cycle();
    check("abort BUSY after drain", int'(BUSY), 0);
    check("abort RUNS", int'(RUNS), 0);
    check("abort no DONE", done_log.size(), 0);
    t0 = cyc; GO = 1'b1; REPS = 8'd1;
    repeat (7) cycle();
    check("post-abort done count", done_log.size(), 1);
    if (done_log.size() == 1) check("post-abort done cycle", done_log[0] - t0, 5);
    check("post-abort RUNS", int'(RUNS), 1);

    // Asynchronous reset in the middle of the fourth run
    GO = 1'b1; REPS = 8'd5;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (m_phase == M_WAIT && m_runs == 3) found = 1'b1;
    end
    check("reached WAIT with RUNS=3", int'(found), 1);
    #2;
    N_RESET = 1'b0;
    model_reset();
    #1;
    check("async START", int'(START), 0);
    check("async BUSY", int'(BUSY), 0);
    check("async DONE", int'(DONE), 0);
    check("async ERR", int'(ERR), 0);
    check("async RUNS", int'(RUNS), 0);
    repeat (2) cycle();
    N_RESET = 1'b1;
    repeat (2) cycle();
    check("after reset BUSY", int'(BUSY), 0);

`ifdef TIMER_SEQ_WDOG_EN
    // Timer never answers: FAULT eight cycles after WAIT entry
    stuck = 1'b1; err_first = -1;
    t0 = cyc; GO = 1'b1; REPS = 8'd1;
    cycle();
    for (int i = 0; i < 12; i++) begin
      GO = 1'b1;
      cycle();
    end
    check("wdog ERR cycle", err_first - t0, 10);
    check("wdog ERR held", int'(ERR), 1);
    check("wdog BUSY in FAULT", int'(BUSY), 0);
    ABORT = 1'b1;
    cycle();
    check("wdog ERR cleared", int'(ERR), 0);
    stuck = 1'b0;
    repeat (2) cycle();
`endif

    // Randomized traffic: GO only when the timer could accept a START
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (ready_at <= cyc && $urandom % 5 == 0) GO = 1'b1;
      else if (m_phase != M_IDLE && $urandom % 4 == 0) GO = 1'b1;
      if ($urandom % 60 == 0) REPS = REPS_W'($urandom_range(250, 255));
      else REPS = REPS_W'($urandom_range(0, 4));
      if ($urandom % 40 == 0) ABORT = 1'b1;
      cycle();
    end
    spur_en = 1'b0;
    repeat (2) cycle();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Initiator-side controller for the fixed-period timer FSM: issues one-cycle START pulses and consumes the timer's one-cycle READY strobes.
- Runs a programmable number of back-to-back timer periods with an optional idle gap between them, then signals completion upstream.
- Sits between a control/host FSM (GO/ABORT/DONE) and a single timer instance with period TIMER_N.

Parameters:
- TIMER_N, 256, period of the attached timer in cycles; must be >= 2. Used for documentation and checks only.
- REPS_W, 8, width of REPS and RUNS.
- GAP, 0, idle cycles between READY and the next START; 0 means back-to-back.
- TIMEOUT, 512, watchdog limit in cycles spent in WAIT or DRAIN; must be > TIMER_N. Used only with TIMER_SEQ_WDOG_EN.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- N_RESET  in  1  asynchronous active-low reset.
- GO  in  1  start request; sampled only in IDLE.
- REPS  in  REPS_W  number of timer runs; latched when GO is accepted.
- ABORT  in  1  cancel the current sequence, or clear FAULT.
- START  out  1  to timer START; high for exactly one cycle per run.
- READY  in  1  from timer READY; one-cycle strobe.
- BUSY  out  1  high while in ARM, WAIT, GAP or DRAIN.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  high while in FAULT.
- RUNS  out  REPS_W  count of completed runs in the current or last sequence.

Behaviour:
- Reset: state IDLE. START, BUSY, DONE and ERR are 0. RUNS is 0. Internal latched reps and counters are 0.
- Registered Moore outputs: START = (state==ARM), DONE = (state==DONE_S), ERR = (state==FAULT).
- States and transitions:
  - IDLE: on GO, latch REPS and clear RUNS. If REPS==0, go to DONE_S; otherwise go to ARM. GO in any other state is ignored.
  - ARM: one cycle, START=1. Go to WAIT.
  - WAIT: on READY, RUNS+1.
    - If the new RUNS equals the latched reps, go to DONE_S.
    - Otherwise go to GAP if GAP>0, or to ARM if GAP==0.
  - GAP: stay GAP cycles, then go to ARM.
  - DONE_S: one cycle, then go to IDLE.
  - DRAIN: entered on ABORT from WAIT, because the timer is mid-period. Wait for READY, then go to IDLE. DONE is not pulsed and RUNS is not incremented.
  - FAULT: see Optional Feature.
- ABORT handling:
  - ABORT in ARM or GAP goes to IDLE.
  - ABORT in WAIT goes to DRAIN, and takes priority over a simultaneous READY.
  - ABORT in DRAIN or IDLE is ignored.
- READY outside WAIT or DRAIN is ignored.
- Timing: START high in cycle c means the timer's READY arrives in cycle c+TIMER_N-1. START is issued only while the timer is in its start state: the cycle after READY is the earliest.
- Back-to-back throughput with GAP=0: one run per TIMER_N cycles.
- RUNS wraps at 2^REPS_W. REPS = 2^REPS_W-1 completes normally.

Optional Feature:
- Macro: TIMER_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT or DRAIN and increments each cycle there.
  - If it reaches TIMEOUT-1 with no READY, the next state is FAULT. READY in that same cycle wins.
  - FAULT: ERR=1, BUSY=0, START=0. Only ABORT exits, going to IDLE. GO is ignored. RUNS holds.
- Not defined: no counter and no FAULT state. ERR is tied to 0. WAIT and DRAIN wait indefinitely.

Test Plan:
- TIMER_N=4, GAP=0, REPS=2, GO in cycle 0 -> START in cycles 1 and 5; READY in cycles 4 and 8; DONE in cycle 9; BUSY in cycles 1-8; RUNS=2.
- REPS=0, GO -> DONE in cycle 1; START never asserted; BUSY stays 0; RUNS=0.
- TIMER_N=4, GAP=3, REPS=2 -> START in cycles 1 and 8; DONE in cycle 12.
- ABORT in cycle 3 of the first run (state WAIT) -> DRAIN; READY in cycle 4 consumed with RUNS=0; IDLE in cycle 5; no DONE. A new GO then starts cleanly.
- With TIMER_SEQ_WDOG_EN, TIMEOUT=8, timer READY stuck low -> ERR rises 8 cycles after entering WAIT. GO is ignored; ABORT returns to IDLE with ERR=0.
- N_RESET low mid-WAIT with RUNS=3 -> all outputs 0 immediately (asynchronous); state IDLE after release.
